// File: rtl/spi_slave_9952_if.sv
// Pin and host-side register port bundle for the AD9952-style SPI responder.
// The slave modport is the responder's view; the master modport drives SPI and serves reads.
interface spi_slave_9952_if #(
  parameter int ADDR_W = 5
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              io_update;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              upd_pulse;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, io_update, rd_data,
    output miso, miso_oe, wr_en, wr_addr, wr_data, rd_req, rd_addr, upd_pulse, busy
  );

  modport master (
    output sclk, cs_n, mosi, io_update, rd_data,
    input  miso, miso_oe, wr_en, wr_addr, wr_data, rd_req, rd_addr, upd_pulse, busy
  );
endinterface

// File: rtl/spi_slave_9952.sv
// AD9952 serial-port responder: oversampled mode-0 SPI slave feeding a host register file.
// Optional SPI_SLAVE_LSB_FIRST_EN adds a lsb_first strap sampled at each cs_n fall.
module spi_slave_9952 #(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input logic lsb_first,
`endif
  spi_slave_9952_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INSTR, WR, RD} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, upd_sync;
  logic sclk_prev, cs_prev, upd_prev;
  logic sclk_s, cs_s, mosi_s, upd_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic active, byte_done, armed, lsb_q;

  logic [2:0]        bit_cnt;
  logic [7:0]        rx_sr, rx_next, tx_sr;
  logic [ADDR_W-1:0] addr;
  logic              pend_wr, pend_rd;
  logic              miso_q, miso_oe_q, wr_en_q, rd_req_q, upd_pulse_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [7:0]        wr_data_q;

  // cs_n chain resets low so a master still holding cs_n low after reset cannot fake a fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      upd_sync  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
      upd_prev  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      upd_sync  <= {upd_sync[SYNC_STAGES-2:0], bus.io_update};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      upd_prev  <= upd_s;
      if (cs_s) armed <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign upd_s     = upd_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = cs_prev & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;
  assign active    = (state != IDLE);

`ifdef SPI_SLAVE_LSB_FIRST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           lsb_q <= 1'b0;
    else if (state == IDLE && cs_fall) lsb_q <= lsb_first;
  end
`else
  assign lsb_q = 1'b0;
`endif

  assign rx_next   = lsb_q ? {mosi_s, rx_sr[7:1]} : {rx_sr[6:0], mosi_s};
  assign byte_done = active & sclk_rise & (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // cs_n rise wins over any decode, but a byte finishing in that clk is still acted on below
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = INSTR;
      INSTR:   if (byte_done) state_next = rx_next[7] ? RD : WR;
      default: ;
    endcase
    if (cs_rise) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= 3'd0;
      rx_sr       <= 8'd0;
      tx_sr       <= 8'd0;
      addr        <= '0;
      pend_wr     <= 1'b0;
      pend_rd     <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      upd_pulse_q <= 1'b0;
    end else begin
      wr_en_q     <= pend_wr;
      rd_req_q    <= pend_rd;
      pend_wr     <= 1'b0;
      pend_rd     <= 1'b0;
      upd_pulse_q <= upd_s & ~upd_prev;

      if (state == IDLE && cs_fall) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 8'd0;
      end else if (active && sclk_rise) begin
        rx_sr   <= rx_next;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        case (state)
          INSTR: begin
            addr <= rx_next[ADDR_W-1:0];
            if (rx_next[7]) begin
              rd_addr_q <= rx_next[ADDR_W-1:0];
              pend_rd   <= 1'b1;
            end
          end
          WR: begin
            wr_addr_q <= addr;
            wr_data_q <= rx_next;
            addr      <= addr + 1'b1;
            pend_wr   <= 1'b1;
          end
          RD: begin
            addr      <= addr + 1'b1;
            rd_addr_q <= addr + 1'b1;
            pend_rd   <= 1'b1;
          end
          default: ;
        endcase
      end

      // the fall right after a byte's last rise (bit_cnt back at 0) must not shift: reload owns it
      if (cs_rise) begin
        miso_q    <= 1'b0;
        miso_oe_q <= 1'b0;
        bit_cnt   <= 3'd0;
      end else if (rd_req_q && state == RD) begin
        tx_sr     <= bus.rd_data;
        miso_q    <= lsb_q ? bus.rd_data[0] : bus.rd_data[7];
        miso_oe_q <= 1'b1;
      end else if (state == RD && miso_oe_q && sclk_fall && bit_cnt != 3'd0) begin
        if (lsb_q) begin
          tx_sr  <= {1'b0, tx_sr[7:1]};
          miso_q <= tx_sr[1];
        end else begin
          tx_sr  <= {tx_sr[6:0], 1'b0};
          miso_q <= tx_sr[6];
        end
      end
    end
  end

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.upd_pulse = upd_pulse_q;
  assign bus.busy      = armed & ~cs_s;

endmodule

// File: tb/tb_spi_slave_9952.sv
// Directed bench for spi_slave_9952: write, read, wrap, abort, io_update and reset mid-read.
`timescale 1ns/1ps
module tb_spi_slave_9952;
  localparam int  ADDR_W = 5;
  localparam time HALF   = 80ns;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_first = 1'b0;
`endif

  spi_slave_9952_if #(.ADDR_W(ADDR_W)) bus ();

  spi_slave_9952 #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:31];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  int          upd_cycles = 0;
  int          upd_rises  = 0;
  logic        upd_last   = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic        oe_and, oe_or;

  // Host register-file model: logs strobes and answers reads on the following clk
  always @(negedge clk) begin
    if (rst) begin
      bus.rd_data = 8'd0;
    end else begin
      if (bus.wr_en) wr_q.push_back({3'd0, bus.wr_addr, bus.wr_data});
      if (bus.rd_req) begin
        rd_q.push_back({3'd0, bus.rd_addr});
        bus.rd_data = mem[bus.rd_addr];
      end
    end
    if (bus.upd_pulse) upd_cycles++;
    if (bus.upd_pulse && !upd_last) upd_rises++;
    upd_last = bus.upd_pulse;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wrAt(input int idx);
    return (idx < wr_q.size()) ? wr_q[idx] : 16'hFFFF;
  endfunction

  function automatic logic [7:0] rdAt(input int idx);
    return (idx < rd_q.size()) ? rd_q[idx] : 8'hFF;
  endfunction

  // Mode 0 master: mosi set while sclk low, miso sampled just before each rise
  task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx     = 8'd0;
    oe_and = 1'b1;
    oe_or  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      #HALF;
      rx     = {rx[6:0], bus.miso};
      oe_and = oe_and & bus.miso_oe;
      oe_or  = oe_or | bus.miso_oe;
      bus.sclk = 1'b1;
      #HALF;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic csStart();
    @(negedge clk);
    bus.cs_n = 1'b0;
    #HALF;
  endtask

  task automatic csEnd();
    #HALF;
    bus.cs_n = 1'b1;
    #(HALF * 2);
  endtask

  task automatic applyUpdate();
    bus.io_update = 1'b1;
    #100ns;
    bus.io_update = 1'b0;
    #100ns;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] rx;
    int wb, rb, u0, r0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.io_update = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    mem[1] = 8'hC3;
    mem[2] = 8'h5A;
    mem[3] = 8'h3E;
    mem[4] = 8'hE0;

    #23ns;
    checkOutput("rst_ctrl", {26'd0, bus.miso, bus.miso_oe, bus.wr_en, bus.rd_req, bus.upd_pulse, bus.busy}, 32'd0);
    checkOutput("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
    checkOutput("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    checkOutput("rst_rd_addr", {27'd0, bus.rd_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("idle_busy", {31'd0, bus.busy}, 32'd0);

    // Two-byte write starting at address 3
    wb = wr_q.size(); rb = rd_q.size();
    csStart();
    applyStimulus(8'h03, 8, rx);
    applyStimulus(8'hA5, 8, rx);
    checkOutput("wr_busy", {31'd0, bus.busy}, 32'd1);
    applyStimulus(8'h3C, 8, rx);
    csEnd();
    checkOutput("wr_count", wr_q.size() - wb, 32'd2);
    checkOutput("wr_first", {16'd0, wrAt(wb)}, 32'h03A5);
    checkOutput("wr_second", {16'd0, wrAt(wb + 1)}, 32'h043C);
    checkOutput("wr_no_rd", rd_q.size() - rb, 32'd0);
    checkOutput("wr_busy_end", {31'd0, bus.busy}, 32'd0);

    // Two-byte read from address 1; a prefetch of address 3 follows the last byte
    wb = wr_q.size(); rb = rd_q.size();
    csStart();
    applyStimulus(8'h81, 8, rx);
    checkOutput("rd_oe_instr", {31'd0, oe_or}, 32'd0);
    applyStimulus(8'h00, 8, rx);
    checkOutput("rd_byte0", {24'd0, rx}, 32'hC3);
    checkOutput("rd_oe_byte0", {31'd0, oe_and}, 32'd1);
    applyStimulus(8'h00, 8, rx);
    checkOutput("rd_byte1", {24'd0, rx}, 32'h5A);
    checkOutput("rd_oe_byte1", {31'd0, oe_and}, 32'd1);
    csEnd();
    checkOutput("rd_count", rd_q.size() - rb, 32'd3);
    checkOutput("rd_addr0", {24'd0, rdAt(rb)}, 32'd1);
    checkOutput("rd_addr1", {24'd0, rdAt(rb + 1)}, 32'd2);
    checkOutput("rd_addr2", {24'd0, rdAt(rb + 2)}, 32'd3);
    checkOutput("rd_no_wr", wr_q.size() - wb, 32'd0);
    checkOutput("rd_end_oe", {30'd0, bus.miso_oe, bus.miso}, 32'd0);

    // Address wraps from 31 to 0
    wb = wr_q.size();
    csStart();
    applyStimulus(8'h1F, 8, rx);
    applyStimulus(8'h11, 8, rx);
    applyStimulus(8'h22, 8, rx);
    csEnd();
    checkOutput("wrap_count", wr_q.size() - wb, 32'd2);
    checkOutput("wrap_first", {16'd0, wrAt(wb)}, 32'h1F11);
    checkOutput("wrap_second", {16'd0, wrAt(wb + 1)}, 32'h0022);

    // Abort a write after 4 data bits, then a read after 4 data bits
    wb = wr_q.size(); rb = rd_q.size();
    csStart();
    applyStimulus(8'h05, 8, rx);
    applyStimulus(8'hF0, 4, rx);
    csEnd();
    checkOutput("abort_wr_count", wr_q.size() - wb, 32'd0);
    checkOutput("abort_wr_oe", {31'd0, bus.miso_oe}, 32'd0);
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    csStart();
    applyStimulus(8'h82, 8, rx);
    applyStimulus(8'h00, 4, rx);
    checkOutput("abort_rd_oe_pre", {31'd0, bus.miso_oe}, 32'd1);
    csEnd();
    checkOutput("abort_rd_end", {30'd0, bus.miso_oe, bus.miso}, 32'd0);
    checkOutput("abort_rd_count", rd_q.size() - rb, 32'd1);
    wb = wr_q.size();
    csStart();
    applyStimulus(8'h06, 8, rx);
    applyStimulus(8'h99, 8, rx);
    csEnd();
    checkOutput("after_abort_count", wr_q.size() - wb, 32'd1);
    checkOutput("after_abort_wr", {16'd0, wrAt(wb)}, 32'h0699);

    // Three io_update pulses, the middle one inside a write
    wb = wr_q.size(); u0 = upd_cycles; r0 = upd_rises;
    applyUpdate();
    fork
      begin
        csStart();
        applyStimulus(8'h0A, 8, rx);
        applyStimulus(8'h5E, 8, rx);
        applyStimulus(8'h6D, 8, rx);
        csEnd();
      end
      begin
        #1600ns;
        applyUpdate();
      end
    join
    applyUpdate();
    repeat (6) @(negedge clk);
    checkOutput("upd_cycles", upd_cycles - u0, 32'd3);
    checkOutput("upd_rises", upd_rises - r0, 32'd3);
    checkOutput("upd_wr_count", wr_q.size() - wb, 32'd2);
    checkOutput("upd_wr0", {16'd0, wrAt(wb)}, 32'h0A5E);
    checkOutput("upd_wr1", {16'd0, wrAt(wb + 1)}, 32'h0B6D);

    // Reset in the middle of a read, stray bits ignored, then a fresh write
    csStart();
    applyStimulus(8'h84, 8, rx);
    applyStimulus(8'h00, 3, rx);
    checkOutput("rrst_oe_pre", {31'd0, bus.miso_oe}, 32'd1);
    #2ns;
    rst = 1'b1;
    #1ns;
    checkOutput("rrst_ctrl", {26'd0, bus.miso, bus.miso_oe, bus.wr_en, bus.rd_req, bus.upd_pulse, bus.busy}, 32'd0);
    checkOutput("rrst_rd_addr", {27'd0, bus.rd_addr}, 32'd0);
    checkOutput("rrst_wr", {19'd0, bus.wr_addr, bus.wr_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb = wr_q.size(); rb = rd_q.size();
    applyStimulus(8'h03, 8, rx);
    applyStimulus(8'h44, 8, rx);
    csEnd();
    checkOutput("rrst_ignored_wr", wr_q.size() - wb, 32'd0);
    checkOutput("rrst_ignored_rd", rd_q.size() - rb, 32'd0);
    csStart();
    applyStimulus(8'h02, 8, rx);
    applyStimulus(8'h77, 8, rx);
    csEnd();
    checkOutput("rrst_wr_count", wr_q.size() - wb, 32'd1);
    checkOutput("rrst_wr_data", {16'd0, wrAt(wb)}, 32'h0277);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
